// File: rtl/user_tree_pkg.sv
// Shared types and widths for the field-tree walker and its depth stack.
package user_tree_pkg;

    localparam int unsigned ID_W          = 8;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned MAX_NODES     = 64;
    localparam int unsigned IDX_W         = $clog2(MAX_NODES);
    localparam int unsigned CNT_W         = IDX_W + 1;
    localparam int unsigned MAX_DEPTH_DEF = 8;

    typedef struct packed {
        logic [ID_W-1:0]   field_id;
        logic              is_msg;
        logic [IDX_W-1:0]  first_child;
        logic [CNT_W-1:0]  num_child;
        logic [DATA_W-1:0] payload;
    } node_entry_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_NOT_FOUND = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } tree_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_EMIT   = 2'd2
    } walker_state_e;

endpackage

// File: rtl/node_tree_stack.sv
// LIFO of parent node indices; top is a combinational read of the newest entry.
module node_tree_stack #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned W       = 6,
    parameter int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       push_data,
    output logic [W-1:0]       top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];

    assign full  = (depth == DEPTH_W'(DEPTH));
    assign empty = (depth == '0);
    assign top   = empty ? '0 : mem[AW'(depth - DEPTH_W'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Entries need no reset: only slots below depth are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(depth)] <= push_data;
        end
    end

endmodule

// File: rtl/node_tree_walker.sv
// Walks a run-time-loaded field tree, one output beat per accepted field beat.
// Optional NODE_TREE_ERR_CNT_EN adds a saturating error-beat counter (err_cnt_o).
module node_tree_walker
    import user_tree_pkg::*;
#(
    parameter  int unsigned MAX_DEPTH = MAX_DEPTH_DEF,
    localparam int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [ID_W-1:0]    field_id_i,
    input  logic               field_end_i,
    input  logic               field_id_valid,
    output logic               field_id_rdy,
    output logic               node_valid,
    input  logic               node_rdy,
    output logic [IDX_W-1:0]   node_idx_o,
    output logic [ID_W-1:0]    node_id_o,
    output logic [DATA_W-1:0]  node_data_o,
    output logic [DEPTH_W-1:0] node_depth_o,
    output logic               node_is_msg_o,
    output logic               node_is_end_o,
    output logic [1:0]         node_err_o,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  node_entry_t        cfg_wdata,
    output logic               cfg_rdy
`ifdef NODE_TREE_ERR_CNT_EN
    ,
    output logic [15:0]        err_cnt_o
`endif
);

    walker_state_e      state;
    logic               idle_q;
    node_entry_t        node_tbl [MAX_NODES];
    logic [IDX_W-1:0]   base_q;
    logic [CNT_W-1:0]   off_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    id_q;

    logic [IDX_W-1:0]   stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               hs;

    logic [IDX_W-1:0]   par_addr;
    logic [IDX_W-1:0]   child_addr;
    logic [ID_W-1:0]    child_id;
    logic               child_msg;
    logic [DATA_W-1:0]  child_payload;

    assign field_id_rdy = idle_q;
    assign cfg_rdy      = idle_q;
    assign hs           = (state == ST_EMIT) && node_valid && node_rdy;

    // Child index wraps naturally in IDX_W bits.
    assign par_addr      = stk_empty ? '0 : stk_top;
    assign child_addr    = base_q + off_q[IDX_W-1:0];
    assign child_id      = node_tbl[child_addr].field_id;
    assign child_msg     = node_tbl[child_addr].is_msg;
    assign child_payload = node_tbl[child_addr].payload;

    node_tree_stack #(
        .DEPTH   (MAX_DEPTH),
        .W       (IDX_W),
        .DEPTH_W (DEPTH_W)
    ) u_stack (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .push      (hs && node_is_msg_o),
        .pop       (hs && node_is_end_o),
        .push_data (node_idx_o),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state         <= ST_IDLE;
            idle_q        <= 1'b1;
            base_q        <= '0;
            off_q         <= '0;
            cnt_q         <= '0;
            id_q          <= '0;
            node_valid    <= 1'b0;
            node_idx_o    <= '0;
            node_id_o     <= '0;
            node_data_o   <= '0;
            node_depth_o  <= '0;
            node_is_msg_o <= 1'b0;
            node_is_end_o <= 1'b0;
            node_err_o    <= ERR_OK;
            for (int i = 0; i < int'(MAX_NODES); i++) begin
                node_tbl[i] <= '0;
            end
        end else begin
            if (cfg_we && idle_q) begin
                node_tbl[cfg_addr] <= cfg_wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (field_id_valid) begin
                        idle_q <= 1'b0;
                        id_q   <= field_id_i;
                        if (field_end_i) begin
                            // End beats bypass the search; the pop commits on handshake.
                            state         <= ST_EMIT;
                            node_valid    <= 1'b1;
                            node_id_o     <= field_id_i;
                            node_idx_o    <= '0;
                            node_data_o   <= '0;
                            node_is_msg_o <= 1'b0;
                            if (stk_empty) begin
                                node_is_end_o <= 1'b0;
                                node_err_o    <= ERR_UNDERFLOW;
                                node_depth_o  <= stk_depth;
                            end else begin
                                node_is_end_o <= 1'b1;
                                node_err_o    <= ERR_OK;
                                node_depth_o  <= stk_depth - DEPTH_W'(1);
                            end
                        end else begin
                            state  <= ST_SEARCH;
                            base_q <= node_tbl[par_addr].first_child;
                            cnt_q  <= node_tbl[par_addr].num_child;
                            off_q  <= '0;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (off_q == cnt_q) begin
                        state         <= ST_EMIT;
                        node_valid    <= 1'b1;
                        node_id_o     <= id_q;
                        node_idx_o    <= '0;
                        node_data_o   <= '0;
                        node_is_msg_o <= 1'b0;
                        node_is_end_o <= 1'b0;
                        node_err_o    <= ERR_NOT_FOUND;
                        node_depth_o  <= stk_depth;
                    end else if (child_id == id_q) begin
                        state         <= ST_EMIT;
                        node_valid    <= 1'b1;
                        node_id_o     <= id_q;
                        node_is_end_o <= 1'b0;
                        if (child_msg && stk_full) begin
                            node_idx_o    <= '0;
                            node_data_o   <= '0;
                            node_is_msg_o <= 1'b0;
                            node_err_o    <= ERR_OVERFLOW;
                            node_depth_o  <= stk_depth;
                        end else begin
                            node_idx_o    <= child_addr;
                            node_data_o   <= child_payload;
                            node_is_msg_o <= child_msg;
                            node_err_o    <= ERR_OK;
                            node_depth_o  <= stk_depth + DEPTH_W'(child_msg);
                        end
                    end else begin
                        off_q <= off_q + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (node_rdy) begin
                        state      <= ST_IDLE;
                        idle_q     <= 1'b1;
                        node_valid <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef NODE_TREE_ERR_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            err_cnt_o <= '0;
        end else if (hs && (node_err_o != ERR_OK) && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_node_tree_walker.sv
// Scoreboard bench for node_tree_walker against a queue/array tree model.
module tb_node_tree_walker;
    import user_tree_pkg::*;

    localparam int unsigned MD = 2;
    localparam int unsigned DW = $clog2(MD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i = 1'b0;
    logic [ID_W-1:0]   field_id_i = '0;
    logic              field_end_i = 1'b0;
    logic              field_id_valid = 1'b0;
    logic              field_id_rdy;
    logic              node_valid;
    logic              node_rdy = 1'b0;
    logic [IDX_W-1:0]  node_idx_o;
    logic [ID_W-1:0]   node_id_o;
    logic [DATA_W-1:0] node_data_o;
    logic [DW-1:0]     node_depth_o;
    logic              node_is_msg_o;
    logic              node_is_end_o;
    logic [1:0]        node_err_o;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_addr = '0;
    node_entry_t       cfg_wdata = '0;
    logic              cfg_rdy;
`ifdef NODE_TREE_ERR_CNT_EN
    logic [15:0]       err_cnt_o;
`endif

    node_tree_walker #(.MAX_DEPTH(MD)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .field_id_i     (field_id_i),
        .field_end_i    (field_end_i),
        .field_id_valid (field_id_valid),
        .field_id_rdy   (field_id_rdy),
        .node_valid     (node_valid),
        .node_rdy       (node_rdy),
        .node_idx_o     (node_idx_o),
        .node_id_o      (node_id_o),
        .node_data_o    (node_data_o),
        .node_depth_o   (node_depth_o),
        .node_is_msg_o  (node_is_msg_o),
        .node_is_end_o  (node_is_end_o),
        .node_err_o     (node_err_o),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdy        (cfg_rdy)
`ifdef NODE_TREE_ERR_CNT_EN
        ,
        .err_cnt_o      (err_cnt_o)
`endif
    );

    typedef struct {
        int idx; int id; int data; int depth;
        int msg; int en; int err; int lat; int acc;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          pcyc = 0;
    int          ecnt = 0;
    bit          hold_low = 1'b0;
    node_entry_t tbl [64];
    int          stk [$];
    exp_t        sb [$];
    exp_t        cur;
    bit          active = 1'b0;

    always @(posedge clk) pcyc++;

    always @(posedge clk) begin
        #1;
        node_rdy = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_out(input exp_t x);
        chk("idx", int'(node_idx_o), x.idx);
        chk("id", int'(node_id_o), x.id);
        chk("data", int'(node_data_o), x.data);
        chk("depth", int'(node_depth_o), x.depth);
        chk("is_msg", int'(node_is_msg_o), x.msg);
        chk("is_end", int'(node_is_end_o), x.en);
        chk("err", int'(node_err_o), x.err);
    endtask

    // Reference: search the parent's child list, then apply stack rules.
    function automatic exp_t model_beat(input int id, input bit e);
        exp_t x;
        int par, f, n, found, kk;
        x = '{default: 0};
        x.id = id;
        if (e) begin
            x.lat = 1;
            if (stk.size() == 0) begin
                x.err = 3;
            end else begin
                void'(stk.pop_back());
                x.en = 1;
            end
            x.depth = stk.size();
            return x;
        end
        par = (stk.size() != 0) ? stk[$] : 0;
        f = int'(tbl[par].first_child);
        n = int'(tbl[par].num_child);
        found = -1;
        kk = 0;
        for (int k = 0; k < n; k++) begin
            if (found < 0 && int'(tbl[(f + k) % 64].field_id) == id) begin
                found = (f + k) % 64;
                kk = k;
            end
        end
        if (found < 0) begin
            x.err = 1;
            x.lat = n + 2;
        end else begin
            x.lat = kk + 2;
            if (tbl[found].is_msg && stk.size() == MD) begin
                x.err = 2;
            end else begin
                x.idx = found;
                x.data = int'(tbl[found].payload);
                x.msg = int'(tbl[found].is_msg);
                if (tbl[found].is_msg) stk.push_back(found);
            end
        end
        x.depth = stk.size();
        return x;
    endfunction

    always @(negedge clk) begin
        if (!reset_i) begin
            active = 1'b0;
        end else if (node_valid) begin
            if (!active) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: node_valid=1 with empty scoreboard (t=%0t)", $time);
                end else begin
                    cur = sb.pop_front();
                    active = 1'b1;
                    chk("latency", pcyc - cur.acc, cur.lat);
                    chk_out(cur);
                end
            end else begin
                chk_out(cur);
            end
            chk("rdy_in_emit", int'(field_id_rdy), 0);
            if (node_rdy && active) begin
                active = 1'b0;
                if (cur.err != 0 && ecnt < 65535) ecnt++;
            end
        end
    end

    function automatic node_entry_t mk(input int id, input bit m, input int fc, input int nc, input int pl);
        node_entry_t e;
        e.field_id    = ID_W'(id);
        e.is_msg      = m;
        e.first_child = IDX_W'(fc);
        e.num_child   = CNT_W'(nc);
        e.payload     = DATA_W'(pl);
        return e;
    endfunction

    task automatic cfg_write(input int a, input node_entry_t e);
        @(negedge clk);
        cfg_addr  = IDX_W'(a);
        cfg_wdata = e;
        cfg_we    = 1'b1;
        if (cfg_rdy) tbl[a] = e;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input int id, input bit e, input bit expect_out);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        field_id_i     = ID_W'(id);
        field_end_i    = e;
        field_id_valid = 1'b1;
        while (!field_id_rdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!field_id_rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: field_id_rdy=0 required 1");
            field_id_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            x = model_beat(id, e);
            x.acc = pcyc;
            sb.push_back(x);
        end
        @(posedge clk);
        #1 field_id_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || node_valid || !field_id_rdy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_i = 1'b1;
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        stk.delete();
        sb.delete();
        ecnt = 0;
    endtask

    task automatic check_idle_after_reset(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, int'(node_valid), 0);
        chk({tag, "_id_rdy"}, int'(field_id_rdy), 1);
        chk({tag, "_cfg_rdy"}, int'(cfg_rdy), 1);
        chk({tag, "_depth"}, int'(node_depth_o), 0);
        chk({tag, "_err"}, int'(node_err_o), 0);
        chk({tag, "_idx"}, int'(node_idx_o), 0);
`ifdef NODE_TREE_ERR_CNT_EN
        chk({tag, "_err_cnt"}, int'(err_cnt_o), 0);
`endif
    endtask

    task automatic load_dir();
        cfg_write(0, mk(0, 0, 1, 3, 16'h1000));
        cfg_write(1, mk(1, 0, 0, 0, 16'h1001));
        cfg_write(2, mk(4, 1, 4, 2, 16'h1002));
        cfg_write(3, mk(7, 0, 0, 0, 16'h1003));
        cfg_write(4, mk(2, 0, 0, 0, 16'h1004));
        cfg_write(5, mk(9, 0, 0, 0, 16'h1005));
    endtask

    task automatic check_err_cnt(input string tag);
`ifdef NODE_TREE_ERR_CNT_EN
        chk(tag, int'(err_cnt_o), ecnt);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        do_reset();
        check_idle_after_reset("reset");
        load_dir();

        // Walk into message node 2, its child, and back out.
        send(4, 0, 1);
        send(9, 0, 1);
        send(0, 1, 1);
        drain();
        // Unknown ID at root, then end at depth 0.
        send(5, 0, 1);
        send(0, 1, 1);
        drain();
        check_err_cnt("err_cnt_dir");

        // Self-referencing message node fills the stack, then overflows.
        cfg_write(1, mk(1, 1, 1, 1, 16'h2001));
        send(1, 0, 1);
        send(1, 0, 1);
        send(1, 0, 1);
        send(0, 1, 1);
        send(0, 1, 1);
        send(0, 1, 1);
        drain();
        cfg_write(1, mk(1, 0, 0, 0, 16'h1001));

        // Output stall: outputs must hold, config writes are dropped.
        hold_low = 1'b1;
        send(1, 0, 1);
        for (int n = 0; n < 50 && !node_valid; n++) @(negedge clk);
        chk("stall_valid", int'(node_valid), 1);
        repeat (5) @(negedge clk);
        chk("stall_cfg_rdy", int'(cfg_rdy), 0);
        cfg_write(1, mk(99, 0, 0, 0, 16'hDEAD));
        repeat (2) @(negedge clk);
        hold_low = 1'b0;
        drain();
        send(1, 0, 1);
        send(99, 0, 1);
        drain();

        // Random tree and random beat stream.
        cfg_write(0, mk(0, 0, 1, 6, 0));
        for (int i = 1; i < 64; i++) begin
            cfg_write(i, mk($urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                            $urandom_range(0, 63), $urandom_range(0, 4), $urandom));
        end
        for (int b = 0; b < 300; b++) begin
            send($urandom_range(0, 7), ($urandom_range(0, 3) == 0), 1);
        end
        drain();
        check_err_cnt("err_cnt_rand");

        // Reset while a long search is in flight.
        do_reset();
        check_idle_after_reset("reset2");
        load_dir();
        send(4, 0, 1);
        send(7, 0, 1);
        drain();
        check_err_cnt("err_cnt_pre");
        cfg_write(2, mk(4, 1, 4, 50, 16'h1002));
        send(200, 0, 0);
        repeat (4) @(negedge clk);
        chk("search_busy_valid", int'(node_valid), 0);
        chk("search_busy_rdy", int'(field_id_rdy), 0);
        do_reset();
        check_idle_after_reset("reset_mid");
        repeat (3) @(negedge clk);
        chk("post_reset_quiet", int'(node_valid), 0);
        load_dir();
        send(4, 0, 1);
        send(0, 1, 1);
        send(0, 1, 1);
        drain();
        check_err_cnt("err_cnt_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
